// File: rtl/bit_stuff_pkg.sv
// Shared USB transmit-path constants.
package bit_stuff_pkg;

    localparam int unsigned USB_MAX_ONES = 6;

endpackage

// File: rtl/bit_stuff.sv
// USB transmit bit stuffer: selects the serial source bit and inserts a 0
// after MAX_ONES consecutive 1s, stalling upstream shifters for that cycle.
module bit_stuff
    import bit_stuff_pkg::*;
#(
    parameter int unsigned MAX_ONES = USB_MAX_ONES
) (
    input  logic gclk,
    input  logic reset_l,
    input  logic start_bit_stuff,
    input  logic stuff_din,
    input  logic shift_tx_crc5,
    input  logic shift_tx_crc16,
    input  logic tx_crc5_out,
    input  logic tx_crc16_out,
    input  logic cs1_l,
    output logic halt_tx_shift,
    output logic stuff_dout,
    output logic start_txd
);

    localparam int unsigned CNT_W = $clog2(MAX_ONES + 1);

    logic [CNT_W-1:0] ones_cnt;
    logic             sel_bit;
    logic             at_max;

    // CRC5 has priority over CRC16, which has priority over packet data.
    always_comb begin
        sel_bit = stuff_din;
        if (shift_tx_crc5) begin
            sel_bit = tx_crc5_out;
        end else if (shift_tx_crc16) begin
            sel_bit = tx_crc16_out;
        end
    end

    assign at_max        = (ones_cnt == CNT_W'(MAX_ONES));
    assign halt_tx_shift = start_bit_stuff & cs1_l & at_max;

    // The run count spans every source so stuffing covers the whole packet.
    always_ff @(posedge gclk or negedge reset_l) begin
        if (!reset_l) begin
            ones_cnt   <= '0;
            stuff_dout <= 1'b0;
            start_txd  <= 1'b0;
        end else if (!cs1_l || !start_bit_stuff) begin
            ones_cnt   <= '0;
            stuff_dout <= 1'b0;
            start_txd  <= 1'b0;
        end else if (at_max) begin
            ones_cnt   <= '0;
            stuff_dout <= 1'b0;
            start_txd  <= 1'b1;
        end else begin
            ones_cnt   <= sel_bit ? ones_cnt + CNT_W'(1) : '0;
            stuff_dout <= sel_bit;
            start_txd  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_stuff.sv
// Randomised and directed checks of bit_stuff against a stream-level model.
module tb_bit_stuff;

    localparam int MAX = 6;

    logic gclk = 1'b0;
    logic reset_l;
    logic start_bit_stuff;
    logic stuff_din;
    logic shift_tx_crc5;
    logic shift_tx_crc16;
    logic tx_crc5_out;
    logic tx_crc16_out;
    logic cs1_l;
    logic halt_tx_shift;
    logic stuff_dout;
    logic start_txd;

    bit_stuff #(.MAX_ONES(MAX)) dut (
        .gclk            (gclk),
        .reset_l         (reset_l),
        .start_bit_stuff (start_bit_stuff),
        .stuff_din       (stuff_din),
        .shift_tx_crc5   (shift_tx_crc5),
        .shift_tx_crc16  (shift_tx_crc16),
        .tx_crc5_out     (tx_crc5_out),
        .tx_crc16_out    (tx_crc16_out),
        .cs1_l           (cs1_l),
        .halt_tx_shift   (halt_tx_shift),
        .stuff_dout      (stuff_dout),
        .start_txd       (start_txd)
    );

    always #5 gclk = ~gclk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_halt  = 0;

    // reference: length of the current run of transmitted 1s, last output bits
    int m_run   = 0;
    bit m_dout  = 1'b0;
    bit m_start = 1'b0;

    bit rec[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit m_sel();
        if (shift_tx_crc5)  return tx_crc5_out;
        if (shift_tx_crc16) return tx_crc16_out;
        return stuff_din;
    endfunction

    function automatic bit m_halt();
        return start_bit_stuff && cs1_l && (m_run == MAX);
    endfunction

    function automatic void m_clear();
        m_run = 0; m_dout = 1'b0; m_start = 1'b0;
    endfunction

    // Outgoing stream: a 0 goes out instead of the next bit once MAX 1s have been sent.
    function automatic void m_edge();
        bit b;
        if (!cs1_l || !start_bit_stuff) begin
            m_clear();
        end else if (m_run == MAX) begin
            m_dout = 1'b0; m_start = 1'b1; m_run = 0;
        end else begin
            b = m_sel();
            m_dout = b; m_start = 1'b1;
            m_run = b ? m_run + 1 : 0;
        end
    endfunction

    // One clock with the inputs already applied; returns just after the edge.
    task automatic cycle();
        #1;
        chk("halt", 32'(halt_tx_shift), 32'(m_halt()));
        if (halt_tx_shift) n_halt++;
        @(posedge gclk);
        m_edge();
        #1;
        chk("dout", 32'(stuff_dout), 32'(m_dout));
        chk("start_txd", 32'(start_txd), 32'(m_start));
        rec.push_back(stuff_dout);
    endtask

    // Present one bit from a source (0 data, 1 crc5, 2 crc16) and hold it while stalled.
    task automatic send(input bit b, input int src);
        bit held;
        shift_tx_crc5  = (src == 1);
        shift_tx_crc16 = (src == 2);
        stuff_din      = (src == 0) ? b : 1'($urandom);
        tx_crc5_out    = (src == 1) ? b : 1'($urandom);
        tx_crc16_out   = (src == 2) ? b : 1'($urandom);
        do begin
            held = m_halt();
            cycle();
        end while (held);
    endtask

    task automatic async_reset();
        #1 reset_l = 1'b0;
        #1;
        m_clear();
        chk("rst_dout", 32'(stuff_dout), 32'd0);
        chk("rst_start", 32'(start_txd), 32'd0);
        chk("rst_halt", 32'(halt_tx_shift), 32'd0);
        #2 reset_l = 1'b1;
    endtask

    task automatic chk_rec(input string tag, input bit exp[$]);
        chk({tag, "_len"}, 32'(rec.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < rec.size(); i++)
            chk(tag, 32'(rec[i]), 32'(exp[i]));
    endtask

    initial begin
        bit exp_q[$];
        reset_l = 1'b0; start_bit_stuff = 1'b0; cs1_l = 1'b1;
        stuff_din = 1'b0; shift_tx_crc5 = 1'b0; shift_tx_crc16 = 1'b0;
        tx_crc5_out = 1'b0; tx_crc16_out = 1'b0;
        #12;
        chk("reset_dout", 32'(stuff_dout), 32'd0);
        chk("reset_start", 32'(start_txd), 32'd0);
        chk("reset_halt", 32'(halt_tx_shift), 32'd0);
        reset_l = 1'b1;
        @(posedge gclk); #1;
        start_bit_stuff = 1'b1;

        // eight 1s then a 0
        rec.delete(); n_halt = 0;
        for (int i = 0; i < 8; i++) send(1'b1, 0);
        send(1'b0, 0);
        exp_q = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
        chk_rec("t1_seq", exp_q);
        chk("t1_halts", 32'(n_halt), 32'd1);

        // zeros and alternating bits pass through untouched
        rec.delete(); n_halt = 0; exp_q.delete();
        for (int i = 0; i < 8; i++) begin send(1'b0, 0); exp_q.push_back(1'b0); end
        for (int i = 0; i < 20; i++) begin send(1'(~i), 0); exp_q.push_back(1'(~i)); end
        chk_rec("t2_seq", exp_q);
        chk("t2_halts", 32'(n_halt), 32'd0);

        // run of 1s carries from data into CRC16
        send(1'b0, 0);
        rec.delete(); n_halt = 0;
        for (int i = 0; i < 4; i++) send(1'b1, 0);
        for (int i = 0; i < 4; i++) send(1'b1, 2);
        exp_q = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
        chk_rec("t3_seq", exp_q);
        chk("t3_halts", 32'(n_halt), 32'd1);

        // async reset after five 1s discards the partial run
        send(1'b0, 0);
        for (int i = 0; i < 5; i++) send(1'b1, 0);
        async_reset();
        rec.delete();
        for (int i = 0; i < 7; i++) send(1'b1, 0);
        exp_q = '{1, 1, 1, 1, 1, 1, 0, 1};
        chk_rec("t4_seq", exp_q);

        // synchronous clear, then disable, in the middle of a run
        send(1'b0, 0);
        for (int i = 0; i < 3; i++) send(1'b1, 0);
        cs1_l = 1'b0; cycle();
        chk("t5_clr_dout", 32'(stuff_dout), 32'd0);
        chk("t5_clr_start", 32'(start_txd), 32'd0);
        cs1_l = 1'b1;
        send(1'b1, 0);
        chk("t5_reen_start", 32'(start_txd), 32'd1);
        for (int i = 0; i < 2; i++) send(1'b1, 0);
        start_bit_stuff = 1'b0; cycle();
        chk("t5_dis_dout", 32'(stuff_dout), 32'd0);
        chk("t5_dis_start", 32'(start_txd), 32'd0);
        start_bit_stuff = 1'b1;
        rec.delete();
        for (int i = 0; i < 7; i++) send(1'b1, 0);
        exp_q = '{1, 1, 1, 1, 1, 1, 0, 1};
        chk_rec("t5_seq", exp_q);

        // CRC5 wins over CRC16
        send(1'b0, 0);
        shift_tx_crc5 = 1'b1; shift_tx_crc16 = 1'b1;
        tx_crc5_out = 1'b1; tx_crc16_out = 1'b0; stuff_din = 1'b0;
        cycle();
        chk("t6_crc5_prio", 32'(stuff_dout), 32'd1);

        // random traffic, biased towards 1s so stuffing is frequent
        for (int i = 0; i < 3000; i++) begin
            start_bit_stuff = ($urandom_range(0, 49) != 0);
            cs1_l           = ($urandom_range(0, 59) != 0);
            shift_tx_crc5   = ($urandom_range(0, 5) == 0);
            shift_tx_crc16  = ($urandom_range(0, 3) == 0);
            stuff_din       = ($urandom_range(0, 9) < 8);
            tx_crc5_out     = ($urandom_range(0, 9) < 8);
            tx_crc16_out    = ($urandom_range(0, 9) < 8);
            cycle();
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
